// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared types and constants for the data-memory access block.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int c_AW  = 16;
    localparam int c_DW  = 16;
    localparam int c_WCW = 3;
    localparam int c_TCW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dm_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dm_wait_cnt
// Description : Wait-state down-counter and ready-timeout up-counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_wait_cnt
    import dm_pkg::*;
#(
    parameter int WAIT_CYC = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_dec,
    input  logic i_tinc,
    output logic o_wait_zero,
    output logic o_timeout_hit
);

    localparam logic [c_WCW-1:0] c_WAIT_LD = c_WCW'(WAIT_CYC);
    localparam logic [c_WCW-1:0] c_W_ONE   = c_WCW'(1);
    localparam logic [c_TCW-1:0] c_T_ONE   = c_TCW'(1);
    // Hit means the next missed ready is the one that exhausts the budget.
    localparam logic [c_TCW-1:0] c_T_LAST  = c_TCW'(TIMEOUT - 1);

    logic [c_WCW-1:0] r_wcnt;
    logic [c_TCW-1:0] r_tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
        end else if (i_load) begin
            r_wcnt <= c_WAIT_LD;
        end else if (i_dec) begin
            r_wcnt <= r_wcnt - c_W_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (i_load) begin
            r_tcnt <= '0;
        end else if (i_tinc) begin
            r_tcnt <= r_tcnt + c_T_ONE;
        end
    end

    assign o_wait_zero   = (r_wcnt == '0);
    assign o_timeout_hit = (r_tcnt == c_T_LAST);

endmodule
`default_nettype wire

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_ctrl
// Description : Single-outstanding wait-stated data-memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int AW       = c_AW,
    parameter int DW       = c_DW,
    parameter int WAIT_CYC = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_ps_dm_en,
    input  logic          i_ps_dm_wrt,
    input  logic [AW-1:0] i_dg_dm_add,
    input  logic [DW-1:0] i_bc_dt,
    output logic          o_dm_ps_stall,
    output logic [AW-1:0] o_dm_mem_add,
    output logic [DW-1:0] o_dm_mem_wdt,
    output logic          o_dm_mem_rd,
    output logic          o_dm_mem_wr,
    input  logic [DW-1:0] i_mem_dm_rdt,
    input  logic          i_mem_dm_rdy,
    output logic [DW-1:0] o_dm_bc_dt,
    output logic          o_dm_bc_vld,
    output logic          o_dm_err
);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_add;
    logic [DW-1:0] r_wdt;
    logic          r_wrt;
    logic          r_err;
    logic [DW-1:0] r_bc_dt;

    logic w_capture, w_load, w_dec, w_tinc, w_rdone, w_tout;
    logic w_wait_zero, w_timeout_hit, w_busy;

    dm_wait_cnt #(
        .WAIT_CYC (WAIT_CYC),
        .TIMEOUT  (TIMEOUT)
    ) u_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_dec         (w_dec),
        .i_tinc        (w_tinc),
        .o_wait_zero   (w_wait_zero),
        .o_timeout_hit (w_timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_load    = 1'b0;
        w_dec     = 1'b0;
        w_tinc    = 1'b0;
        w_rdone   = 1'b0;
        w_tout    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_ps_dm_en) begin
                    w_capture = 1'b1;
                    w_next    = ST_REQ;
                end else begin
                    w_next    = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_load = 1'b1;
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!w_wait_zero) begin
                    w_dec = 1'b1;
                end else if (i_mem_dm_rdy) begin
                    w_rdone = 1'b1;
                    w_next  = ST_DONE;
                end else if (w_timeout_hit) begin
                    w_tout = 1'b1;
                    w_next = ST_DONE;
                end else begin
                    w_tinc = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add   <= '0;
            r_wdt   <= '0;
            r_wrt   <= 1'b0;
            r_err   <= 1'b0;
            r_bc_dt <= '0;
        end else begin
            if (w_capture) begin
                r_add <= i_dg_dm_add;
                r_wdt <= i_bc_dt;
                r_wrt <= i_ps_dm_wrt;
            end
            if (w_rdone || w_tout) begin
                r_err <= w_tout;
            end
            // A timed-out read still returns a (zero) value so the consumer is never left waiting.
            if (w_rdone && !r_wrt) begin
                r_bc_dt <= i_mem_dm_rdt;
            end else if (w_tout && !r_wrt) begin
                r_bc_dt <= '0;
            end
        end
    end

    assign w_busy        = (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign o_dm_ps_stall = w_busy;
    assign o_dm_mem_rd   = w_busy && !r_wrt;
    assign o_dm_mem_wr   = w_busy && r_wrt;
    assign o_dm_mem_add  = r_add;
    assign o_dm_mem_wdt  = r_wdt;
    assign o_dm_bc_dt    = r_bc_dt;
    assign o_dm_bc_vld   = (r_state == ST_DONE) && !r_wrt;
    assign o_dm_err      = (r_state == ST_DONE) && r_err;

endmodule
`default_nettype wire
